hvac_actuator_ctrl: RTL
=======================

Name: hvac_actuator_ctrl

Overview:
Downstream stage of the air-conditioning monitor. Consumes the monitor's heating/cooling request levels and drives the physical actuators: heater, compressor and fan. Enforces a minimum on-time, a compressor restart lockout and a fan overrun after every run. Moore FSM plus two timers; outputs are registered.

Parameters:
MIN_ON, 4, minimum consecutive cycles heater_on/compressor_on stay high once asserted
MIN_OFF, 6, compressor restart lockout in cycles after compressor_on falls (and after reset)
FAN_OVERRUN, 3, cycles fan_on stays high alone after a heat/cool run ends
CNT_W, 4, timer width; must hold max(MIN_ON, MIN_OFF, FAN_OVERRUN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
heating  input  1  heat request level from monitor
cooling  input  1  cool request level from monitor
heater_on  output  1  heater drive
compressor_on  output  1  compressor drive
fan_on  output  1  fan drive
lockout  output  1  high while compressor restart is inhibited
fault  output  1  sticky: heating and cooling seen high together
state  output  3  current FSM state, for debug

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: state=IDLE; heater_on=compressor_on=fan_on=0; fault=0; lockout=1; lockout timer loaded with MIN_OFF.
- States and outputs (Moore, decoded from state register):
  - IDLE: all actuators 0.
  - HEAT: heater_on=1, fan_on=1.
  - COOL: compressor_on=1, fan_on=1.
  - FAN_RUN: fan_on=1 only.
- Request decoding per edge:
  - req_heat = heating & ~cooling.
  - req_cool = cooling & ~heating.
  - heating & cooling both high: treated as no request; fault set, held until reset.
- Transitions:
  - IDLE: req_heat -> HEAT. Else req_cool & ~lockout -> COOL. Else stay.
  - HEAT/COOL: on-timer clears on entry and increments each cycle, saturating. Exit to FAN_RUN only when the request is low and MIN_ON cycles have elapsed. The earliest exit edge is entry edge + MIN_ON.
  - FAN_RUN: overrun timer clears on entry.
    - req_heat -> HEAT.
    - Else req_cool & ~lockout -> COOL.
    - Else after FAN_OVERRUN cycles -> IDLE.
    - A re-entry keeps fan_on high continuously.
  - Direct HEAT<->COOL transitions are forbidden; a change of request always passes through FAN_RUN.
- Latency: request high at edge k -> actuator high after edge k (visible cycle k+1), provided the state allows it.
- Lockout timer:
  - Reloaded with MIN_OFF on the edge leaving COOL, then decrements by 1 per cycle to 0, saturating.
  - lockout = (timer != 0).
  - compressor_on cannot re-rise before exit edge + MIN_OFF + 1.
  - After reset release, the earliest COOL entry is the (MIN_OFF+1)th edge.
- req_cool while locked out: the request is held pending, not dropped. FSM waits in IDLE/FAN_RUN, and FAN_RUN still times out to IDLE.
- Reset mid-run: all outputs drop immediately (asynchronously); lockout is reasserted.

Decomposition:
- Shared package hvac_pkg: FSM state encodings (IDLE=0, HEAT=1, COOL=2, FAN_RUN=3) and default timing constants. The monitor and bench reuse them.
- One natural sub-module: hvac_timer, a parameterised CNT_W load/clear/saturating counter with a zero flag. Instantiate it for the on/overrun timer and the lockout timer.

Test Plan:
1. Reset release, cooling=1 held -> lockout=1 for 6 cycles; compressor_on and fan_on rise after the 7th edge; fault=0.
2. heating=1 for a single cycle from IDLE (lockout clear) -> heater_on high exactly 4 cycles, then fan_on alone 3 cycles, then all 0 in IDLE.
3. Cool run ends, cooling re-asserted 2 cycles later -> fan overrun 3 cycles, then IDLE with lockout=1; compressor_on re-rises exactly 7 edges after the COOL exit edge.
4. heating re-asserted during cycle 2 of FAN_RUN -> HEAT on the next edge, fan_on never drops, heater_on high again for ≥4 cycles.
5. heating=cooling=1 for 1 cycle during IDLE -> fault=1 permanently, actuators stay 0; later heating alone still runs normally; fault clears only on rst_n=0.
6. rst_n pulled low mid-COOL between clock edges -> compressor_on, fan_on and state go to 0 within the same cycle; after release lockout=1 and the MIN_OFF inhibit applies again.

Source files
------------

// File: rtl/hvac_pkg.sv
// ----------------------------------------------------------------------------
// hvac_pkg
// Shared definitions for the HVAC actuator controller, its timers and any
// block that needs to interpret the controller's debug state output.
//   state_t        : FSM encodings (IDLE=0, HEAT=1, COOL=2, FAN_RUN=3)
//   *_DEF          : default timing constants in clock cycles
//   decode_heat/cool : mutually exclusive request decode
// ----------------------------------------------------------------------------
package hvac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEAT    = 3'd1,
        ST_COOL    = 3'd2,
        ST_FAN_RUN = 3'd3
    } state_t;

    localparam int MIN_ON_DEF      = 4;
    localparam int MIN_OFF_DEF     = 6;
    localparam int FAN_OVERRUN_DEF = 3;
    localparam int CNT_W_DEF       = 4;

    // Conflicting requests decode to "no request" on both sides.
    function automatic logic decode_heat(input logic heat, input logic cool);
        return heat & ~cool;
    endfunction

    function automatic logic decode_cool(input logic heat, input logic cool);
        return cool & ~heat;
    endfunction

endpackage

// File: rtl/hvac_timer.sv
// ----------------------------------------------------------------------------
// hvac_timer
// Saturating up/down counter with clear, load and zero flag.
// Priority: clear > load > increment > decrement.
//   clk, rst_n     : clock, async active-low reset (count -> RST_VAL)
//   i_clr          : force count to zero
//   i_load         : load i_load_val
//   i_inc / i_dec  : count up (saturates at all-ones) / down (saturates at 0)
//   o_count        : current count
//   o_zero         : count == 0
// ----------------------------------------------------------------------------
module hvac_timer
    import hvac_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= RST_VAL;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/hvac_actuator_ctrl.sv
// ----------------------------------------------------------------------------
// hvac_actuator_ctrl
// Drives heater, compressor and fan from the monitor's heat/cool request
// levels. Moore FSM with a minimum on-time, a fan overrun after each run and
// a compressor restart lockout.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   IDLE     | all actuators off
//   HEAT     | heater + fan on, held at least MIN_ON cycles
//   COOL     | compressor + fan on, held at least MIN_ON cycles
//   FAN_RUN  | fan alone for FAN_OVERRUN cycles, or until re-entry
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   heating, cooling      : request levels from the monitor
//   heater_on, compressor_on, fan_on : actuator drives (decoded from state)
//   lockout               : compressor restart inhibited
//   fault                 : sticky, both requests seen together
//   state                 : current FSM state (debug)
// ----------------------------------------------------------------------------
module hvac_actuator_ctrl
    import hvac_pkg::*;
#(
    parameter int MIN_ON      = MIN_ON_DEF,
    parameter int MIN_OFF     = MIN_OFF_DEF,
    parameter int FAN_OVERRUN = FAN_OVERRUN_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heating,
    input  logic       cooling,
    output logic       heater_on,
    output logic       compressor_on,
    output logic       fan_on,
    output logic       lockout,
    output logic       fault,
    output logic [2:0] state
);

    // The run timer clears on the entry edge, so after j cycles in a state it
    // reads j-1; an exit on the Nth edge after entry needs count >= N-1.
    localparam logic [CNT_W-1:0] C_ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] C_OVR_LAST = CNT_W'(FAN_OVERRUN - 1);
    localparam logic [CNT_W-1:0] C_MIN_OFF  = CNT_W'(MIN_OFF);

    state_t           r_state;
    state_t           w_next;
    logic             r_fault;
    logic             w_req_heat;
    logic             w_req_cool;
    logic             w_conflict;
    logic [CNT_W-1:0] w_run_cnt;
    logic             w_on_done;
    logic             w_ovr_done;
    logic             w_state_chg;
    logic             w_cool_exit;
    logic             w_lock_zero;
    logic             w_lockout;
    logic             w_unused_run_zero;
    logic [CNT_W-1:0] w_unused_lock_cnt;

    assign w_req_heat = decode_heat(heating, cooling);
    assign w_req_cool = decode_cool(heating, cooling);
    assign w_conflict = heating & cooling;

    assign w_on_done   = (w_run_cnt >= C_ON_LAST);
    assign w_ovr_done  = (w_run_cnt >= C_OVR_LAST);
    assign w_state_chg = (w_next != r_state);
    assign w_cool_exit = (r_state == ST_COOL) && (w_next != ST_COOL);
    assign w_lockout   = ~w_lock_zero;

    // Shared on-time / overrun timer: restarts on every state change.
    hvac_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL ('0)
    ) u_run_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_state_chg),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (1'b1),
        .i_dec      (1'b0),
        .o_count    (w_run_cnt),
        .o_zero     (w_unused_run_zero)
    );

    // Restart lockout: armed out of reset and on every COOL exit.
    hvac_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (C_MIN_OFF)
    ) u_lock_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (1'b0),
        .i_load     (w_cool_exit),
        .i_load_val (C_MIN_OFF),
        .i_inc      (1'b0),
        .i_dec      (1'b1),
        .o_count    (w_unused_lock_cnt),
        .o_zero     (w_lock_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_conflict) begin
            r_fault <= 1'b1;
        end
    end

    // A cool request while locked out is simply not acted on; since it is a
    // level, it is picked up as soon as the lockout expires.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req_heat) begin
                    w_next = ST_HEAT;
                end else if (w_req_cool && !w_lockout) begin
                    w_next = ST_COOL;
                end
            end
            ST_HEAT: begin
                if (!w_req_heat && w_on_done) begin
                    w_next = ST_FAN_RUN;
                end
            end
            ST_COOL: begin
                if (!w_req_cool && w_on_done) begin
                    w_next = ST_FAN_RUN;
                end
            end
            ST_FAN_RUN: begin
                if (w_req_heat) begin
                    w_next = ST_HEAT;
                end else if (w_req_cool && !w_lockout) begin
                    w_next = ST_COOL;
                end else if (w_ovr_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        heater_on     = 1'b0;
        compressor_on = 1'b0;
        fan_on        = 1'b0;
        case (r_state)
            ST_HEAT: begin
                heater_on = 1'b1;
                fan_on    = 1'b1;
            end
            ST_COOL: begin
                compressor_on = 1'b1;
                fan_on        = 1'b1;
            end
            ST_FAN_RUN: fan_on = 1'b1;
            default: ;
        endcase
    end

    assign lockout = w_lockout;
    assign fault   = r_fault;
    assign state   = r_state;

endmodule
